imem_arbiter: RTL and testbench

- Single-point owner of the single-port instruction memory; shares it between the core instruction-fetch port and a program-loader write port.
- Sequences boot: only the loader owns the memory until loading completes, then the core is released to fetch.
- In run mode, fetches and late loader writes are round-robin arbitrated.
- Memory side is a plain req/we/addr/wdata port with 1-cycle read latency.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_arbiter_rr_arb2.sv | 25 ++
 rtl/imem_arbiter.sv | 102 ++++++++++
 tb/tb_imem_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and address helpers for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  localparam int MEM_WORDS_DEF = 128;
  localparam int IMEM_AW       = $clog2(MEM_WORDS_DEF);

  function automatic logic [29:0] word_addr(input logic [31:0] a);
    return a[31:2];
  endfunction

  function automatic logic in_range(input logic [31:0] a, input int unsigned words);
    return {2'b00, a[31:2]} < 32'(words);
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Index 0 is fetch, index 1 is loader.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;  // index of the winner of the last contested cycle

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) gnt_o = last_q ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                 last_q <= 1'b1;
    else if (en_i && &req_i)   last_q <= ~last_q;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Owns the single-port instruction memory: loader-only during BOOT, then
// round-robin between core fetch and late loader writes in RUN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int          MEM_WORDS = MEM_WORDS_DEF,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0100,
  localparam int         AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_req_i,
  input  logic [31:0]   load_addr_i,
  input  logic [31:0]   load_wdata_i,
  input  logic          load_done_i,
  output logic          load_gnt_o,
  output logic          load_err_o,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  output logic          fetch_en_o,
  output logic [31:0]   boot_addr_o,
  output logic [AW:0]   boot_words_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  state_e      state_q, state_d;
  logic        rvalid_q, rd_q, ierr_q, lerr_q;
  logic [31:0] rdata_hold_q;
  logic [AW:0] bw_q;

  logic        run, load_in, instr_in, load_gnt, instr_gnt;
  logic [1:0]  arb_gnt;
  logic [29:0] load_wa, instr_wa;

  assign run      = (state_q == RUN);
  assign load_in  = in_range(load_addr_i, MEM_WORDS);
  assign instr_in = in_range(instr_addr_i, MEM_WORDS);
  assign load_wa  = word_addr(load_addr_i);
  assign instr_wa = word_addr(instr_addr_i);

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (run && !rst_i),
    .req_i ({load_req_i, instr_req_i}),
    .gnt_o (arb_gnt)
  );

  assign load_gnt  = !rst_i && (run ? arb_gnt[1] : load_req_i);
  assign instr_gnt = !rst_i && run && arb_gnt[0];

  assign load_gnt_o  = load_gnt;
  assign instr_gnt_o = instr_gnt;
  assign mem_req_o   = (load_gnt && load_in) || (instr_gnt && instr_in);
  assign mem_we_o    = load_gnt && load_in;
  assign mem_addr_o  = load_gnt ? load_wa[AW-1:0] : instr_wa[AW-1:0];
  assign mem_wdata_o = load_wdata_i;

  // Gating with rst_i drops a response launched the cycle before reset.
  assign instr_rvalid_o = rvalid_q && !rst_i;
  assign instr_err_o    = ierr_q && !rst_i;
  assign instr_rdata_o  = rvalid_q ? (rd_q ? mem_rdata_i : 32'h0) : rdata_hold_q;
  assign load_err_o     = lerr_q;
  assign fetch_en_o     = run;
  assign boot_addr_o    = BOOT_ADDR;
  assign boot_words_o   = bw_q;

  always_comb begin
    state_d = state_q;
    if (!run && load_done_i) state_d = RUN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= BOOT;
      rvalid_q     <= 1'b0;
      rd_q         <= 1'b0;
      ierr_q       <= 1'b0;
      lerr_q       <= 1'b0;
      rdata_hold_q <= 32'h0;
      bw_q         <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= instr_gnt;
      rd_q     <= instr_gnt && instr_in;
      ierr_q   <= instr_gnt && !instr_in;
      lerr_q   <= load_gnt && !load_in;
      if (rvalid_q) rdata_hold_q <= instr_rdata_o;
      if (!run && load_gnt && load_in && bw_q < (AW+1)'(MEM_WORDS))
        bw_q <= bw_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed table-driven bench for imem_arbiter plus reset and saturation sequences.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        lr, ld, ir;
  logic [31:0] la, lw, ia, mr;
  logic        load_gnt, load_err, instr_gnt, rvalid, ierr, fetch_en;
  logic [31:0] rdata, boot_addr, mwdata;
  logic [7:0]  bw;
  logic        mreq, mwe;
  logic [6:0]  maddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .load_req_i(lr), .load_addr_i(la), .load_wdata_i(lw), .load_done_i(ld),
    .load_gnt_o(load_gnt), .load_err_o(load_err),
    .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(ierr),
    .fetch_en_o(fetch_en), .boot_addr_o(boot_addr), .boot_words_o(bw),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_rdata_i(mr)
  );

  typedef struct {
    logic lr; logic [31:0] la; logic [31:0] lw; logic ld;
    logic ir; logic [31:0] ia; logic [31:0] mr;
    logic lg; logic ig; logic mq; logic we; logic [6:0] ma;
    logic rv; logic [31:0] rd; logic er; logic fe; logic le; logic [7:0] bw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic drive(input logic r, input logic ilr, input logic [31:0] ila,
                       input logic [31:0] ilw, input logic ild, input logic iir,
                       input logic [31:0] iia, input logic [31:0] imr);
    @(posedge clk); #1;
    rst = r; lr = ilr; la = ila; lw = ilw; ld = ild; ir = iir; ia = iia; mr = imr;
    @(negedge clk);
  endtask

  function automatic vec_t v(logic ilr, logic [31:0] ila, logic [31:0] ilw, logic ild,
                             logic iir, logic [31:0] iia, logic [31:0] imr,
                             logic lg, logic ig, logic mq, logic we, logic [6:0] ma,
                             logic rv, logic [31:0] rd, logic er, logic fe, logic le,
                             logic [7:0] ebw);
    vec_t t;
    t.lr = ilr; t.la = ila; t.lw = ilw; t.ld = ild; t.ir = iir; t.ia = iia; t.mr = imr;
    t.lg = lg; t.ig = ig; t.mq = mq; t.we = we; t.ma = ma;
    t.rv = rv; t.rd = rd; t.er = er; t.fe = fe; t.le = le; t.bw = ebw;
    return t;
  endfunction

  vec_t tv[$];

  initial begin
    //        lr la      lw            ld ir ia      mr             lg ig mq we ma   rv rd            er fe le bw
    tv.push_back(v(1,'h100,'h01000093,0, 1,'h100,0,             1,0,1,1,64,  0,0,            0,0,0,0));
    tv.push_back(v(1,'h104,'h01000093,0, 1,'h100,0,             1,0,1,1,65,  0,0,            0,0,0,1));
    tv.push_back(v(1,'h108,'h01000093,0, 1,'h100,0,             1,0,1,1,66,  0,0,            0,0,0,2));
    tv.push_back(v(0,0,0,1,              1,'h100,0,             0,0,0,0,0,   0,0,            0,0,0,3));
    tv.push_back(v(0,0,0,0,              1,'h100,0,             0,1,1,0,64,  0,0,            0,1,0,3));
    tv.push_back(v(0,0,0,0,              0,0,'h01000093,        0,0,0,0,0,   1,'h01000093,   0,1,0,3));
    tv.push_back(v(1,'h10C,'hAAAA,0,     1,'h104,0,             0,1,1,0,65,  0,'h01000093,   0,1,0,3));
    tv.push_back(v(1,'h10C,'hAAAA,0,     1,'h104,'h11111111,    1,0,1,1,67,  1,'h11111111,   0,1,0,3));
    tv.push_back(v(1,'h10C,'hAAAA,0,     1,'h104,0,             0,1,1,0,65,  0,'h11111111,   0,1,0,3));
    tv.push_back(v(1,'h10C,'hAAAA,0,     1,'h104,'h22222222,    1,0,1,1,67,  1,'h22222222,   0,1,0,3));
    tv.push_back(v(0,0,0,1,              0,0,0,                 0,0,0,0,0,   0,'h22222222,   0,1,0,3));
    tv.push_back(v(0,0,0,0,              1,'h200,0,             0,1,0,0,0,   0,'h22222222,   0,1,0,3));
    tv.push_back(v(0,0,0,0,              0,0,'hDEADBEEF,        0,0,0,0,0,   1,0,            1,1,0,3));
    tv.push_back(v(1,'h200,'h5,0,        0,0,0,                 1,0,0,0,0,   0,0,            0,1,0,3));
    tv.push_back(v(0,0,0,0,              1,'h1FC,0,             0,1,1,0,127, 0,0,            0,1,1,3));
    tv.push_back(v(0,0,0,0,              0,0,'h33333333,        0,0,0,0,0,   1,'h33333333,   0,1,0,3));
    tv.push_back(v(1,'h110,'h7,0,        1,'h100,0,             0,1,1,0,64,  0,'h33333333,   0,1,0,3));
    tv.push_back(v(0,0,0,0,              0,0,'h44444444,        0,0,0,0,0,   1,'h44444444,   0,1,0,3));

    rst = 1; lr = 0; la = 0; lw = 0; ld = 0; ir = 0; ia = 0; mr = 0;
    drive(1, 0, 0, 0, 0, 1, 'h100, 0);
    drive(1, 1, 'h100, 1, 0, 1, 'h100, 0);
    chk("rst_load_gnt", load_gnt, 0);
    chk("rst_instr_gnt", instr_gnt, 0);
    chk("rst_mem_req", mreq, 0);
    chk("rst_mem_we", mwe, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_boot_words", bw, 0);
    chk("rst_load_err", load_err, 0);
    chk("boot_addr", boot_addr, 32'h100);

    foreach (tv[i]) begin
      drive(0, tv[i].lr, tv[i].la, tv[i].lw, tv[i].ld, tv[i].ir, tv[i].ia, tv[i].mr);
      chk($sformatf("v%0d_load_gnt", i), load_gnt, tv[i].lg);
      chk($sformatf("v%0d_instr_gnt", i), instr_gnt, tv[i].ig);
      chk($sformatf("v%0d_mem_req", i), mreq, tv[i].mq);
      chk($sformatf("v%0d_mem_we", i), mwe, tv[i].we);
      if (tv[i].mq) chk($sformatf("v%0d_mem_addr", i), maddr, tv[i].ma);
      if (tv[i].we) chk($sformatf("v%0d_mem_wdata", i), mwdata, tv[i].lw);
      chk($sformatf("v%0d_rvalid", i), rvalid, tv[i].rv);
      chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
      chk($sformatf("v%0d_err", i), ierr, tv[i].er);
      chk($sformatf("v%0d_fetch_en", i), fetch_en, tv[i].fe);
      chk($sformatf("v%0d_load_err", i), load_err, tv[i].le);
      chk($sformatf("v%0d_boot_words", i), bw, tv[i].bw);
    end

    // Fetch granted, reset on the following cycle: the response must vanish.
    drive(0, 0, 0, 0, 0, 1, 'h100, 0);
    chk("mid_instr_gnt", instr_gnt, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 'h55555555);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_err", ierr, 0);
    drive(0, 0, 0, 0, 0, 1, 'h100, 0);
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_fetch_en", fetch_en, 0);
    chk("post_rst_boot_words", bw, 0);
    chk("post_rst_instr_gnt", instr_gnt, 0);

    // 130 in-range BOOT writes: the word counter saturates at MEM_WORDS.
    for (int k = 0; k < 130; k++) begin
      drive(0, 1, 32'((k % 128) * 4), 32'(k), 0, 0, 0, 0);
      if (k == 127) chk("sat_last_addr", maddr, 127);
      if (k == 128) chk("sat_bw_128", bw, 128);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_bw_final", bw, 128);
    chk("sat_fetch_en", fetch_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
